// File: rtl/sd_read_block_dat.sv
// SDIO slave DAT-line receiver for host-to-card block writes.
// Samples the raw DAT lines on rising sd_clock edges (seen through a
// synchroniser), finds the start bit, deserialises bytes, checks the
// per-line CRC16 and the end bit, and repeats for every block.
//
// Strobe protocol: write_byte_strobe, block_done_strobe, all_done_strobe and
// timeout_strobe are single-cycle pulses with no back-pressure. byte_out is
// valid only while write_byte_strobe=1; block_crc_ok/block_end_ok are valid
// only while block_done_strobe=1. The sink must accept on every pulse.
module sd_read_block_dat #(
  parameter int DATA_LINES     = 4,
  parameter int SIZE_WIDTH     = 12,
  parameter int COUNT_WIDTH    = 9,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sd_clock,
  input  logic [DATA_LINES-1:0]  sd_data,
  input  logic                   read_strobe,
  input  logic [SIZE_WIDTH-1:0]  block_size,
  input  logic [COUNT_WIDTH-1:0] block_count,
  input  logic                   abort,
  output logic                   write_byte_strobe,
  output logic [7:0]             byte_out,
  output logic                   block_done_strobe,
  output logic                   block_crc_ok,
  output logic                   block_end_ok,
  output logic                   all_done_strobe,
  output logic                   timeout_strobe,
  output logic                   busy
);

  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EPB = 8 / DATA_LINES;  // sd_clock edges per byte

  localparam logic [TW-1:0]          TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]             BIT_LAST   = 3'(EPB - 1);
  localparam logic [SIZE_WIDTH-1:0]  SIZE_ONE   = SIZE_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [DATA_LINES-1:0]  LINES_HIGH = {DATA_LINES{1'b1}};
  localparam logic [DATA_LINES-1:0]  LINES_LOW  = {DATA_LINES{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_DATA       = 3'd2,
    S_CRC        = 3'd3,
    S_END        = 3'd4
  } state_t;

  // CCITT CRC16, x^16+x^12+x^5+1, one serial bit per call.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Synchroniser and sampled data
  logic                  s1_q, s2_q, s3_q;
  logic [DATA_LINES-1:0] d_q, d_prev_q;

  // FSM and datapath state
  state_t                 state_q, state_d;
  logic [SIZE_WIDTH-1:0]  size_q, size_d;
  logic [SIZE_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic [COUNT_WIDTH-1:0] blocks_q, blocks_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [7:0]             shift_q, shift_d;
  logic [15:0]            crc_q [DATA_LINES];
  logic [15:0]            crc_d [DATA_LINES];
  logic [15:0]            crc_next [DATA_LINES];
  logic [3:0]             crc_idx_q, crc_idx_d;
  logic                   crc_ok_q, crc_ok_d;

  // Registered outputs
  logic       wbs_q, wbs_d;
  logic [7:0] byte_out_q, byte_out_d;
  logic       bds_q, bds_d;
  logic       bcrc_q, bcrc_d;
  logic       bend_q, bend_d;
  logic       alld_q, alld_d;
  logic       to_q, to_d;
  logic       busy_q, busy_d;

  // Event decode
  logic       sd_rise;
  logic       accept;
  logic       start_bit;
  logic       timer_hit;
  logic       byte_done;
  logic       last_byte;
  logic       crc_last;
  logic       last_block;
  logic       crc_mismatch;
  logic [3:0] d4;
  logic [7:0] shift_in;

  assign sd_rise    = s2_q & ~s3_q;
  assign accept     = read_strobe && (block_size != '0) && (block_count != '0);
  assign start_bit  = sd_rise && (d_prev_q == LINES_HIGH) && (d_q == LINES_LOW);
  assign timer_hit  = (timer_q == TIMER_LAST);
  assign byte_done  = (bit_cnt_q == BIT_LAST);
  assign last_byte  = (byte_cnt_q == SIZE_ONE);
  assign crc_last   = (crc_idx_q == 4'd0);
  assign last_block = (blocks_q == COUNT_ONE);
  assign d4         = 4'(d_q);

  // Shift register input: DAT3 is the nibble MSB, or DAT0 alone for 1-line.
  always_comb begin
    shift_in = shift_q;
    if (DATA_LINES == 4) shift_in = {shift_q[3:0], d4};
    else                 shift_in = {shift_q[6:0], d4[0]};
  end

  // Per-line CRC next values and comparison against the received CRC bits.
  always_comb begin
    crc_mismatch = 1'b0;
    for (int i = 0; i < DATA_LINES; i++) begin
      crc_next[i] = crc16_step(crc_q[i], d_q[i]);
      if (d_q[i] != crc_q[i][crc_idx_q]) crc_mismatch = 1'b1;
    end
  end

  // Synchronise sd_clock, register the DAT lines, keep the previous edge's data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      d_q      <= '0;
      d_prev_q <= '0;
    end else begin
      s1_q <= sd_clock;
      s2_q <= s1_q;
      s3_q <= s2_q;
      d_q  <= sd_data;
      if (sd_rise) d_prev_q <= d_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:       if (accept) state_d = S_WAIT_START;
        S_WAIT_START: begin
          if (start_bit)      state_d = S_DATA;
          else if (timer_hit) state_d = S_IDLE;
        end
        S_DATA:       if (sd_rise && byte_done && last_byte) state_d = S_CRC;
        S_CRC:        if (sd_rise && crc_last) state_d = S_END;
        S_END:        if (sd_rise) state_d = last_block ? S_IDLE : S_WAIT_START;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // FSM output / datapath next values; strobes default low every cycle.
  always_comb begin
    size_d     = size_q;
    byte_cnt_d = byte_cnt_q;
    blocks_d   = blocks_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = timer_q;
    shift_d    = shift_q;
    crc_idx_d  = crc_idx_q;
    crc_ok_d   = crc_ok_q;
    for (int i = 0; i < DATA_LINES; i++) crc_d[i] = crc_q[i];
    wbs_d      = 1'b0;
    byte_out_d = byte_out_q;
    bds_d      = 1'b0;
    bcrc_d     = bcrc_q;
    bend_d     = bend_q;
    alld_d     = 1'b0;
    to_d       = 1'b0;
    busy_d     = (state_d != S_IDLE);

    if (!abort) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            size_d   = block_size;
            blocks_d = block_count;
            timer_d  = '0;
            crc_ok_d = 1'b1;
            for (int i = 0; i < DATA_LINES; i++) crc_d[i] = 16'h0000;
          end else if (read_strobe) begin
            // Zero-length transfer: nothing to receive, report completion.
            alld_d = 1'b1;
          end
        end
        S_WAIT_START: begin
          timer_d = timer_q + 1'b1;
          if (start_bit) begin
            byte_cnt_d = size_q;
            bit_cnt_d  = 3'd0;
          end else if (timer_hit) begin
            to_d = 1'b1;
          end
        end
        S_DATA: begin
          if (sd_rise) begin
            shift_d = shift_in;
            for (int i = 0; i < DATA_LINES; i++) crc_d[i] = crc_next[i];
            if (byte_done) begin
              bit_cnt_d  = 3'd0;
              wbs_d      = 1'b1;
              byte_out_d = shift_in;
              byte_cnt_d = byte_cnt_q - 1'b1;
              if (last_byte) crc_idx_d = 4'd15;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        S_CRC: begin
          if (sd_rise) begin
            if (crc_mismatch) crc_ok_d = 1'b0;
            if (!crc_last) crc_idx_d = crc_idx_q - 1'b1;
          end
        end
        S_END: begin
          if (sd_rise) begin
            bds_d    = 1'b1;
            bcrc_d   = crc_ok_q;
            bend_d   = (d_q == LINES_HIGH);
            blocks_d = blocks_q - 1'b1;
            if (last_block) begin
              alld_d = 1'b1;
            end else begin
              timer_d  = '0;
              crc_ok_d = 1'b1;
              for (int i = 0; i < DATA_LINES; i++) crc_d[i] = 16'h0000;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      size_q     <= '0;
      byte_cnt_q <= '0;
      blocks_q   <= '0;
      bit_cnt_q  <= 3'd0;
      timer_q    <= '0;
      shift_q    <= 8'h00;
      crc_idx_q  <= 4'd0;
      crc_ok_q   <= 1'b0;
      for (int i = 0; i < DATA_LINES; i++) crc_q[i] <= 16'h0000;
    end else begin
      size_q     <= size_d;
      byte_cnt_q <= byte_cnt_d;
      blocks_q   <= blocks_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      crc_idx_q  <= crc_idx_d;
      crc_ok_q   <= crc_ok_d;
      for (int i = 0; i < DATA_LINES; i++) crc_q[i] <= crc_d[i];
    end
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wbs_q      <= 1'b0;
      byte_out_q <= 8'h00;
      bds_q      <= 1'b0;
      bcrc_q     <= 1'b0;
      bend_q     <= 1'b0;
      alld_q     <= 1'b0;
      to_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wbs_q      <= wbs_d;
      byte_out_q <= byte_out_d;
      bds_q      <= bds_d;
      bcrc_q     <= bcrc_d;
      bend_q     <= bend_d;
      alld_q     <= alld_d;
      to_q       <= to_d;
      busy_q     <= busy_d;
    end
  end

  assign write_byte_strobe = wbs_q;
  assign byte_out          = byte_out_q;
  assign block_done_strobe = bds_q;
  assign block_crc_ok      = bcrc_q;
  assign block_end_ok      = bend_q;
  assign all_done_strobe   = alld_q;
  assign timeout_strobe    = to_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_sd_read_block_dat.sv
// Bench for sd_read_block_dat: a 4-line and a 1-line receiver share the SD
// bus model; expected bytes and block results are queued by the drivers and
// checked by one monitor on every negative clock edge.
module tb_sd_read_block_dat;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        sd_clock;
  logic [3:0]  sd_data;
  logic        rs4, rs1;
  logic [11:0] block_size;
  logic [8:0]  block_count;
  logic        abort;

  logic       wbs4, bds4, bcrc4, bend4, alld4, to4, busy4;
  logic [7:0] byte4;
  logic       wbs1, bds1, bcrc1, bend1, alld1, to1, busy1;
  logic [7:0] byte1;

  sd_read_block_dat #(.DATA_LINES(4), .SIZE_WIDTH(12), .COUNT_WIDTH(9), .TIMEOUT_CYCLES(100)) dut4 (
    .clock(clock), .reset(reset), .sd_clock(sd_clock), .sd_data(sd_data),
    .read_strobe(rs4), .block_size(block_size), .block_count(block_count), .abort(abort),
    .write_byte_strobe(wbs4), .byte_out(byte4), .block_done_strobe(bds4),
    .block_crc_ok(bcrc4), .block_end_ok(bend4), .all_done_strobe(alld4),
    .timeout_strobe(to4), .busy(busy4));

  sd_read_block_dat #(.DATA_LINES(1), .SIZE_WIDTH(12), .COUNT_WIDTH(9), .TIMEOUT_CYCLES(100)) dut1 (
    .clock(clock), .reset(reset), .sd_clock(sd_clock), .sd_data(sd_data[0]),
    .read_strobe(rs1), .block_size(block_size), .block_count(block_count), .abort(abort),
    .write_byte_strobe(wbs1), .byte_out(byte1), .block_done_strobe(bds1),
    .block_crc_ok(bcrc1), .block_end_ok(bend1), .all_done_strobe(alld1),
    .timeout_strobe(to1), .busy(busy1));

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q4[$];
  logic [7:0] exp_q1[$];
  logic [2:0] blk_q4[$];  // {crc_ok, end_ok, last_block}
  logic [2:0] blk_q1[$];
  int exp_alld4 = 0, exp_alld1 = 0, exp_to4 = 0, exp_to1 = 0;
  int nbytes4 = 0, nblk4 = 0, nall4 = 0;
  logic [2:0] rec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Monitor: every strobe must match the head of the expectation queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (wbs4) begin
        nbytes4++;
        check("byte4 pending", exp_q4.size() != 0, 1);
        if (exp_q4.size() != 0) check("byte4 value", byte4, exp_q4.pop_front());
      end
      if (bds4) begin
        nblk4++;
        check("block4 pending", blk_q4.size() != 0, 1);
        if (blk_q4.size() != 0) begin
          rec = blk_q4.pop_front();
          check("block4 crc_ok", bcrc4, rec[2]);
          check("block4 end_ok", bend4, rec[1]);
          check("block4 all_done", alld4, rec[0]);
        end
      end else if (alld4) begin
        check("all_done4 expected", exp_alld4 > 0, 1);
        if (exp_alld4 > 0) exp_alld4--;
      end
      if (alld4) nall4++;
      if (to4) begin
        check("timeout4 expected", exp_to4 > 0, 1);
        if (exp_to4 > 0) exp_to4--;
      end
      if (wbs1) begin
        check("byte1 pending", exp_q1.size() != 0, 1);
        if (exp_q1.size() != 0) check("byte1 value", byte1, exp_q1.pop_front());
      end
      if (bds1) begin
        check("block1 pending", blk_q1.size() != 0, 1);
        if (blk_q1.size() != 0) begin
          rec = blk_q1.pop_front();
          check("block1 crc_ok", bcrc1, rec[2]);
          check("block1 end_ok", bend1, rec[1]);
          check("block1 all_done", alld1, rec[0]);
        end
      end else if (alld1) begin
        check("all_done1 expected", exp_alld1 > 0, 1);
        if (exp_alld1 > 0) exp_alld1--;
      end
      if (to1) begin
        check("timeout1 expected", exp_to1 > 0, 1);
        if (exp_to1 > 0) exp_to1--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [15:0] crc_m[4];

  // One SD bit period (6 system clocks): data changes while sd_clock is low.
  task automatic sd_edge(input logic [3:0] v);
    sd_data = v;
    repeat (3) @(posedge clock);
    #1 sd_clock = 1'b1;
    repeat (3) @(posedge clock);
    #1 sd_clock = 1'b0;
  endtask

  task automatic tx_start(input int idle);
    repeat (idle) sd_edge(4'hF);
    sd_edge(4'h0);
    for (int i = 0; i < 4; i++) crc_m[i] = 16'h0000;
  endtask

  task automatic tx_nib(input logic [3:0] v);
    for (int i = 0; i < 4; i++) crc_m[i] = crc_step(crc_m[i], v[i]);
    sd_edge(v);
  endtask

  task automatic tx_byte4(input logic [7:0] b);
    tx_nib(b[7:4]);
    tx_nib(b[3:0]);
  endtask

  task automatic tx_byte1(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) begin
      crc_m[0] = crc_step(crc_m[0], b[k]);
      sd_edge({3'b111, b[k]});
    end
  endtask

  task automatic tx_crc_end(input int lines, input int flip_line, input int flip_bit,
                            input logic [3:0] endv);
    logic [3:0] v;
    for (int k = 15; k >= 0; k--) begin
      v = 4'hF;
      for (int i = 0; i < lines; i++) v[i] = crc_m[i][k];
      if (flip_line >= 0 && k == flip_bit) v[flip_line] = ~v[flip_line];
      sd_edge(v);
    end
    sd_edge(endv);
  endtask

  task automatic start_read(input int which, input int size, input int cnt);
    block_size  = 12'(size);
    block_count = 9'(cnt);
    if (which == 4) rs4 = 1'b1;
    else            rs1 = 1'b1;
    @(posedge clock);
    #1;
    rs4 = 1'b0;
    rs1 = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200; k++) begin
      if (exp_q4.size() == 0 && exp_q1.size() == 0 && blk_q4.size() == 0 && blk_q1.size() == 0)
        break;
      @(posedge clock);
    end
    repeat (4) @(posedge clock);
    #1;
    check(name, exp_q4.size() + exp_q1.size() + blk_q4.size() + blk_q1.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] tbl3[8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
  logic [7:0] b;
  int nb0, nk0, na0, found, kcnt;
  logic [15:0] pin;
  string ascii;

  initial begin
    reset = 1'b1; sd_clock = 1'b0; sd_data = 4'hF; rs4 = 1'b0; rs1 = 1'b0;
    block_size = '0; block_count = '0; abort = 1'b0;

    // Model pin: CRC16/XMODEM of "123456789" is 0x31C3.
    ascii = "123456789";
    pin = 16'h0000;
    for (int j = 0; j < 9; j++) begin
      b = ascii[j];
      for (int k = 7; k >= 0; k--) pin = crc_step(pin, b[k]);
    end
    check("crc model pin", pin, 16'h31C3);

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset outputs4", {wbs4, byte4, bds4, bcrc4, bend4, alld4, to4, busy4}, 0);
    check("reset outputs1", {wbs1, byte1, bds1, bcrc1, bend1, alld1, to1, busy1}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock); #1;

    // 4-line single block 12 34 56 78
    exp_q4.push_back(8'h12); exp_q4.push_back(8'h34);
    exp_q4.push_back(8'h56); exp_q4.push_back(8'h78);
    blk_q4.push_back(3'b111);
    start_read(4, 4, 1);
    check("busy after read_strobe", busy4, 1);
    tx_start(2);
    tx_byte4(8'h12); tx_byte4(8'h34); tx_byte4(8'h56); tx_byte4(8'h78);
    tx_crc_end(4, -1, 0, 4'hF);
    drain("drain single block");
    check("busy after single block", busy4, 0);
    check("single block bytes", nbytes4, 4);

    // 1-line block A5 3C
    exp_q1.push_back(8'hA5); exp_q1.push_back(8'h3C);
    blk_q1.push_back(3'b111);
    start_read(1, 2, 1);
    tx_start(2);
    tx_byte1(8'hA5); tx_byte1(8'h3C);
    tx_crc_end(1, -1, 0, 4'hF);
    drain("drain 1-line block");
    check("busy1 after block", busy1, 0);

    // DAT2 CRC bit 7 flipped
    for (int i = 0; i < 8; i++) exp_q4.push_back(tbl3[i]);
    blk_q4.push_back(3'b011);
    start_read(4, 8, 1);
    tx_start(2);
    for (int i = 0; i < 8; i++) tx_byte4(tbl3[i]);
    tx_crc_end(4, 2, 7, 4'hF);
    drain("drain crc error block");

    // Three blocks of 8 bytes with 10-period gaps
    nb0 = nbytes4; nk0 = nblk4; na0 = nall4;
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 8; i++) exp_q4.push_back(8'(blk * 16 + i * 3 + 1));
      blk_q4.push_back(blk == 2 ? 3'b111 : 3'b110);
    end
    start_read(4, 8, 3);
    for (int blk = 0; blk < 3; blk++) begin
      tx_start(10);
      for (int i = 0; i < 8; i++) tx_byte4(8'(blk * 16 + i * 3 + 1));
      tx_crc_end(4, -1, 0, 4'hF);
    end
    drain("drain multi block");
    check("multi byte strobes", nbytes4 - nb0, 24);
    check("multi block strobes", nblk4 - nk0, 3);
    check("multi all_done strobes", nall4 - na0, 1);

    // Timeout: lines held high, no start bit
    sd_data = 4'hF;
    exp_to4 = 1;
    nb0 = nbytes4;
    start_read(4, 4, 1);
    found = 0;
    kcnt = 200;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (to4) begin
        kcnt = k;
        found = 1;
        check("busy at timeout", busy4, 0);
        break;
      end
    end
    check("timeout latency", kcnt, 100);
    check("timeout seen", found, 1);
    @(posedge clock); #1;
    check("timeout no bytes", nbytes4 - nb0, 0);

    // Abort after byte 3 (plus half a byte) of a 512-byte block
    exp_q4.push_back(8'h11); exp_q4.push_back(8'h22); exp_q4.push_back(8'h33);
    start_read(4, 512, 1);
    tx_start(2);
    tx_byte4(8'h11); tx_byte4(8'h22); tx_byte4(8'h33);
    tx_nib(4'h4);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    repeat (2) @(posedge clock); #1;
    check("busy after abort", busy4, 0);
    tx_nib(4'h5); tx_nib(4'h6); tx_nib(4'h7);
    drain("drain aborted transfer");
    exp_q4.push_back(8'h9A); exp_q4.push_back(8'hBC);
    exp_q4.push_back(8'hDE); exp_q4.push_back(8'hF0);
    blk_q4.push_back(3'b111);
    start_read(4, 4, 1);
    tx_start(2);
    tx_byte4(8'h9A); tx_byte4(8'hBC); tx_byte4(8'hDE); tx_byte4(8'hF0);
    tx_crc_end(4, -1, 0, 4'hF);
    drain("drain after abort");

    // End bit low on DAT1
    exp_q4.push_back(8'hC3); exp_q4.push_back(8'h5A);
    exp_q4.push_back(8'h0F); exp_q4.push_back(8'hF0);
    blk_q4.push_back(3'b101);
    start_read(4, 4, 1);
    tx_start(2);
    tx_byte4(8'hC3); tx_byte4(8'h5A); tx_byte4(8'h0F); tx_byte4(8'hF0);
    tx_crc_end(4, -1, 0, 4'b1101);
    drain("drain end-bit block");

    // Zero-size read completes immediately
    exp_alld4 = 1;
    start_read(4, 0, 1);
    check("zero-size all_done", alld4, 1);
    check("zero-size busy", busy4, 0);
    repeat (3) @(posedge clock); #1;
    check("zero-size consumed", exp_alld4, 0);

    // abort and read_strobe together: abort wins
    abort = 1'b1;
    start_read(4, 4, 1);
    abort = 1'b0;
    check("abort beats read_strobe", busy4, 0);
    repeat (3) @(posedge clock); #1;

    check("timeout expectations consumed", exp_to4, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/sd_read_block_dat.md
Name: sd_read_block_dat

Overview:
- SDIO slave data-line receiver for host-to-card writes (CMD53 block or byte mode).
- Samples DAT lines on rising sd_clock edges, detects the start bit, deserialises bytes, checks per-line CRC16 and the end bit, and repeats for multi-block transfers.
- Feeds the byte sink (FIFO/register file) and reports per-block status to the CRC-status response generator.
- Successor of the single-block 4-bit receiver: adds a parametrised bus width (1 or 4 lines), a block count, end-bit checking, a start-bit timeout and abort.

Parameters:
- DATA_LINES, 4, number of DAT lines used; legal values 1 or 4.
- SIZE_WIDTH, 12, width of block_size; max block 4095 bytes.
- COUNT_WIDTH, 9, width of block_count.
- TIMEOUT_CYCLES, 65535, clock cycles allowed in WAIT_START before timeout; must be >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- sd_clock  in  1  raw SD clock, asynchronous
- sd_data  in  DATA_LINES  raw DAT lines; bit 0 = DAT0
- read_strobe  in  1  one-cycle pulse: start transfer
- block_size  in  SIZE_WIDTH  bytes per block, latched on read_strobe
- block_count  in  COUNT_WIDTH  number of blocks, latched on read_strobe
- abort  in  1  one-cycle pulse: cancel transfer
- write_byte_strobe  out  1  byte_out valid, one cycle
- byte_out  out  8  received byte, MSB first on the wire
- block_done_strobe  out  1  block finished, one cycle
- block_crc_ok  out  1  valid while block_done_strobe=1
- block_end_ok  out  1  end bit seen high on all lines; valid while block_done_strobe=1
- all_done_strobe  out  1  last block finished, one cycle
- timeout_strobe  out  1  start bit not seen in time, one cycle
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser and data registers 0.
- sd_clock passes through 2 flops (s1, s2) plus a delay flop s3. The edge is detected when s2=1 and s3=0. sd_data is registered once into d, and d is used on the edge cycle. d_prev holds d from the previous edge.
- All outputs are registered. Every strobe is high the cycle after the edge cycle that completes its event.
- States: IDLE, WAIT_START, DATA, CRC, END.
- IDLE:
  - read_strobe with block_size != 0 and block_count != 0: latch both inputs, clear CRCs, clear the timeout counter, go to WAIT_START.
  - read_strobe with either value 0: all_done_strobe next cycle, stay IDLE.
- WAIT_START:
  - Timeout counter increments every clock.
  - On an edge with d_prev all-ones and d all-zeros: go to DATA, reset the byte counter to block_size.
  - If the counter reaches TIMEOUT_CYCLES first: timeout_strobe, go to IDLE.
- DATA:
  - Each edge shifts in DATA_LINES bits. DAT3 carries the MSB of each nibble; with 1 line, DAT0 only.
  - Line i feeds CRC16 engine i: polynomial x^16+x^12+x^5+1, init 0.
  - A byte completes every 8/DATA_LINES edges: write_byte_strobe, byte_out set, byte counter decremented.
  - After the byte where the counter equals 1, go to CRC with bit index 15.
- CRC:
  - 16 edges. Each compares line i against crc[i][index], MSB first, and clears a sticky crc_ok on any mismatch.
  - CRC engines are frozen during this state.
- END:
  - One edge. end_ok = (d all-ones).
  - Next cycle: block_done_strobe, block_crc_ok, block_end_ok.
  - Decrement the remaining block count. If it was 1: all_done_strobe in the same cycle as block_done_strobe, go to IDLE. Otherwise clear CRCs, crc_ok=1, clear the timeout counter, go to WAIT_START.
- Abort:
  - From any state: go to IDLE next cycle with no strobes. A partially received byte is discarded.
  - abort and read_strobe in the same cycle: abort wins.
- read_strobe while busy: ignored.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0.
- Counter widths: byte counter SIZE_WIDTH bits, block counter COUNT_WIDTH bits, timeout counter ceil(log2(TIMEOUT_CYCLES+1)) bits. No wrap is possible because every counter is checked before it decrements or overflows.

Test Plan:
- 4-line, 1 block of 4 bytes 0x12 0x34 0x56 0x78, correct CRCs, end bit 1 -> four write_byte_strobes with those values in order; block_done with crc_ok=1 and end_ok=1; all_done in the same cycle; busy=0 afterwards.
- DATA_LINES=1, 1 block of 2 bytes 0xA5 0x3C -> 16 data edges, bytes 0xA5 and 0x3C; crc_ok=1.
- 4-line, 8-byte block with DAT2 CRC bit 7 flipped -> all 8 bytes delivered; block_crc_ok=0; end_ok=1.
- 4-line, block_count=3, block_size=8, valid data, each gap 10 sd_clock periods -> 24 byte strobes, 3 block_done strobes, exactly one all_done coinciding with the third.
- TIMEOUT_CYCLES=100, lines held high after read_strobe -> timeout_strobe exactly 100 cycles after entering WAIT_START; no byte strobes; busy drops.
- abort pulsed after byte 3 of a 512-byte block, then a new read_strobe with a 4-byte block -> no further strobes from the first transfer; second transfer completes with crc_ok=1.
- End bit driven low on DAT1 -> block_end_ok=0; block_crc_ok=1.
